// File: rtl/obstacle_spawner.sv
// Obstacle spawn scheduler: frame-based gap countdown, lowest-free-slot pick, LFSR sprite type.
// Optional OBSTACLE_SPAWN_PAIR_EN: two slots released together when lfsr[15] is set and two are free.
module obstacle_spawner #(
  parameter logic [15:0] SEED      = 16'hACE1,
  parameter int unsigned MIN_GAP   = 40,
  parameter logic [15:0] GAP_MASK  = 16'h003F,
  parameter logic [3:0]  TYPE_MASK = 4'h7
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_frame_tick,
  input  logic [1:0]  i_game_state,
  input  logic [2:0]  i_slot_busy,
  output logic [2:0]  o_release,
  output logic [3:0]  o_sel1,
  output logic [3:0]  o_sel2,
  output logic [3:0]  o_sel3,
  output logic [15:0] o_spawn_count
);

  localparam logic [15:0] SEED_EFF   = (SEED == 16'h0000) ? 16'hACE1 : SEED;
  localparam logic [15:0] MIN_GAP_16 = MIN_GAP[15:0];

  typedef enum logic [1:0] {
    S_WAIT_GAP = 2'd0,
    S_PICK     = 2'd1,
    S_RELEASE  = 2'd2
  } state_t;

  function automatic logic [15:0] gap_load(input logic [15:0] lfsr);
    return MIN_GAP_16 + (lfsr & GAP_MASK);
  endfunction

  state_t      r_state;
  state_t      w_state_next;
  logic [15:0] r_lfsr;
  logic [15:0] r_gap_cnt;
  logic [2:0]  r_reserved;
  logic [2:0]  r_pick;
  logic [15:0] r_spawn_count;
  logic [3:0]  r_sel [3];

  logic        w_running;
  logic        w_idle;
  logic [15:0] w_lfsr_next;
  logic [2:0]  w_free;
  logic [2:0]  w_first;
  logic [2:0]  w_rest;
  logic [2:0]  w_second;
  logic        w_pair;
  logic [2:0]  w_pick_mask;
  logic [3:0]  w_type;
  logic [3:0]  w_type2;
  logic        w_do_pick;
  logic        w_tick_zero;
  logic        w_releasing;
  logic [2:0]  w_release;
  logic [1:0]  w_pick_cnt;
  logic [16:0] w_count_sum;
  logic [15:0] w_count_next;

  assign w_running   = (i_game_state == 2'd1);
  assign w_idle      = (i_game_state == 2'd0);
  assign w_lfsr_next = {1'b0, r_lfsr[15:1]} ^ (r_lfsr[0] ? 16'hB400 : 16'h0000);

  // A slot handed out last release stays reserved until the delegate reports it busy.
  assign w_free = ~i_slot_busy & ~r_reserved;

  // NOTE: every signal assigned in always_comb gets a default first, so no path can infer a latch.
  always_comb begin
    w_first = 3'b000;
    if (w_free[0])      w_first = 3'b001;
    else if (w_free[1]) w_first = 3'b010;
    else if (w_free[2]) w_first = 3'b100;
  end

  assign w_rest = w_free & ~w_first;

  always_comb begin
    w_second = 3'b000;
    if (w_rest[0])      w_second = 3'b001;
    else if (w_rest[1]) w_second = 3'b010;
    else if (w_rest[2]) w_second = 3'b100;
  end

`ifdef OBSTACLE_SPAWN_PAIR_EN
  assign w_pair = r_lfsr[15] && (w_second != 3'b000);
`else
  assign w_pair = 1'b0;
`endif

  assign w_pick_mask = w_first | (w_pair ? w_second : 3'b000);
  assign w_type      = r_lfsr[3:0] & TYPE_MASK;
  assign w_type2     = (w_type + 4'd1) & TYPE_MASK;
  assign w_do_pick   = (r_state == S_PICK) && w_running && (w_free != 3'b000);
  assign w_tick_zero = w_running && i_frame_tick && (r_gap_cnt == 16'd0);

  // State register
  always_ff @(posedge clk) begin
    if (rst) r_state <= S_WAIT_GAP;
    else     r_state <= w_state_next;
  end

  // Next-state logic; IDLE forces the scheduler back to its start point every cycle.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_WAIT_GAP: if (w_tick_zero) w_state_next = S_PICK;
      S_PICK:     if (w_do_pick)   w_state_next = S_RELEASE;
      S_RELEASE:                   w_state_next = S_WAIT_GAP;
      default:                     w_state_next = S_WAIT_GAP;
    endcase
    if (w_idle) w_state_next = S_WAIT_GAP;
  end

  // Output logic; a reset or IDLE arriving during RELEASE suppresses the pulse in that cycle.
  always_comb begin
    w_releasing = (r_state == S_RELEASE) && !rst && !w_idle;
    w_release   = w_releasing ? r_pick : 3'b000;
  end

  assign w_pick_cnt   = {1'b0, r_pick[0]} + {1'b0, r_pick[1]} + {1'b0, r_pick[2]};
  assign w_count_sum  = {1'b0, r_spawn_count} + {15'd0, w_pick_cnt};
  assign w_count_next = w_count_sum[16] ? 16'hFFFF : w_count_sum[15:0];

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_lfsr        <= SEED_EFF;
      r_gap_cnt     <= gap_load(SEED_EFF);
      r_reserved    <= 3'b000;
      r_pick        <= 3'b000;
      r_spawn_count <= 16'd0;
      // NOTE: this tiny select array is reset explicitly because the delegate reads it from power-up.
      for (int i = 0; i < 3; i++) r_sel[i] <= 4'd0;
    end else begin
      r_lfsr <= w_lfsr_next;
      if (w_idle) begin
        r_gap_cnt  <= gap_load(r_lfsr);
        r_reserved <= 3'b000;
      end else begin
        // Setting a reservation wins over a same-cycle busy clear.
        r_reserved <= (r_reserved & ~i_slot_busy) | w_release;
        if ((r_state == S_WAIT_GAP) && w_running && i_frame_tick && (r_gap_cnt != 16'd0))
          r_gap_cnt <= r_gap_cnt - 16'd1;
        if (w_releasing) begin
          r_gap_cnt     <= gap_load(r_lfsr);
          r_spawn_count <= w_count_next;
        end
        if (w_do_pick) begin
          r_pick <= w_pick_mask;
          for (int i = 0; i < 3; i++) begin
            if (w_first[i])                r_sel[i] <= w_type;
            else if (w_pair && w_second[i]) r_sel[i] <= w_type2;
          end
        end
      end
    end
  end

  assign o_release     = w_release;
  assign o_sel1        = r_sel[0];
  assign o_sel2        = r_sel[1];
  assign o_sel3        = r_sel[2];
  assign o_spawn_count = r_spawn_count;

endmodule
